// File: rtl/hcsr04_pkg.sv
// Shared definitions for the multi-channel HC-SR04 ranger: FSM state encoding,
// 50 MHz default timing constants and a channel-index width helper.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    CALC      = 3'd4,
    DONE      = 3'd5,
    HOLDOFF   = 3'd6
  } state_e;

  localparam int unsigned DEF_NUM_CH      = 32'd2;
  localparam int unsigned DEF_TRIG_CYC    = 32'd500;
  localparam int unsigned DEF_ECHO_TO     = 32'd1_250_000;
  localparam int unsigned DEF_ECHO_MAX    = 32'd1_250_000;
  localparam int unsigned DEF_PERIOD_CYC  = 32'd5_000_000;
  localparam int unsigned DEF_CNT_W       = 32'd23;
  localparam int unsigned DEF_SCALE_MUL   = 32'd1446;
  localparam int unsigned DEF_SCALE_SHIFT = 32'd22;
  localparam int unsigned DEF_DIST_W      = 32'd12;

  // A single sensor still needs a 1-bit channel tag.
  function automatic int unsigned ch_w(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/hcsr04_ranger_mc_if.sv
// Control, sensor and result signals of the ranger; master drives control and
// echo lines, slave is the ranger itself.
interface hcsr04_ranger_mc_if
  import hcsr04_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DIST_W = DEF_DIST_W,
  parameter int unsigned CH_W   = ch_w(NUM_CH)
);
  logic              enable;
  logic              single_shot;
  logic              start;
  logic [NUM_CH-1:0] echo_in;
  logic [NUM_CH-1:0] trigger_out;
  logic [DIST_W-1:0] dist_data;
  logic [CH_W-1:0]   dist_ch;
  logic              dist_valid;
  logic              dist_timeout;
  logic              busy;

  modport master (
    output enable, single_shot, start, echo_in,
    input  trigger_out, dist_data, dist_ch, dist_valid, dist_timeout, busy
  );

  modport slave (
    input  enable, single_shot, start, echo_in,
    output trigger_out, dist_data, dist_ch, dist_valid, dist_timeout, busy
  );
endinterface

// File: rtl/hcsr04_echo_sync.sv
// Two-flop synchroniser for one asynchronous echo line, with an extra history
// flop so that single-cycle rise and fall pulses can be derived.
module hcsr04_echo_sync (
  input  logic clk,
  input  logic n_rst,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  // synchroniser chain plus edge-history flop
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/hcsr04_ranger_mc.sv
// Round-robin HC-SR04 ranger: one sensor per PERIOD_CYC slot, trigger pulse,
// echo-width measurement and scaled, saturated distance with timeout flag.
module hcsr04_ranger_mc
  import hcsr04_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
  parameter int unsigned ECHO_TO     = DEF_ECHO_TO,
  parameter int unsigned ECHO_MAX    = DEF_ECHO_MAX,
  parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SCALE_MUL   = DEF_SCALE_MUL,
  parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int unsigned DIST_W      = DEF_DIST_W
) (
  input  logic               clk,
  input  logic               n_rst,
  hcsr04_ranger_mc_if.slave  bus
);
  localparam int unsigned CH_W   = ch_w(NUM_CH);
  localparam int unsigned PROD_W = CNT_W + 32'd16;

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYC - 32'd1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(ECHO_TO - 32'd1);
  localparam logic [CNT_W-1:0] WIDTH_MAX   = CNT_W'(ECHO_MAX);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 32'd1);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 32'd1);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic [NUM_CH-1:0]  trigger_q, trig_s;
  logic [DIST_W-1:0]  dist_data_q;
  logic [CH_W-1:0]    dist_ch_q;
  logic               dist_valid_q;
  logic               dist_timeout_q;
  logic               busy_q;

  logic [NUM_CH-1:0]  rise_s, fall_s;
  logic               rise_ch_s, fall_ch_s;
  logic               timeout_s;
  logic               wrap_s;
  logic [PROD_W-1:0]  product_s, shifted_s;
  logic [DIST_W-1:0]  scaled_s;

  function automatic logic [DIST_W-1:0] saturate(input logic [PROD_W-1:0] v);
    if (|v[PROD_W-1:DIST_W]) begin
      return '1;
    end else begin
      return v[DIST_W-1:0];
    end
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    hcsr04_echo_sync u_sync (
      .clk    (clk),
      .n_rst  (n_rst),
      .echo_i (bus.echo_in[g]),
      .rise_o (rise_s[g]),
      .fall_o (fall_s[g])
    );
  end

  // Only the channel owning the current slot is observed.
  assign rise_ch_s = rise_s[ch_q];
  assign fall_ch_s = fall_s[ch_q];

  assign product_s = PROD_W'(width_q) * PROD_W'(SCALE_MUL);
  assign shifted_s = product_s >> SCALE_SHIFT;
  assign scaled_s  = saturate(shifted_s);

  // next-state, channel pointer and wait/width counters
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wait_cnt_d = wait_cnt_q;
    width_d    = width_q;
    timeout_s  = 1'b0;
    wrap_s     = (ch_q == CH_LAST);
    case (state_q)
      IDLE: begin
        if (bus.enable && (!bus.single_shot || bus.start)) begin
          state_d = TRIG;
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        if (slot_cnt_q == TRIG_LAST) begin
          state_d    = WAIT_RISE;
          wait_cnt_d = '0;
        end else begin
          state_d = TRIG;
        end
      end
      WAIT_RISE: begin
        // The rise cycle is already the first high cycle of the echo.
        if (rise_ch_s) begin
          state_d = MEASURE;
          width_d = CNT_W'(1);
        end else if (wait_cnt_q == TO_LAST) begin
          state_d   = DONE;
          timeout_s = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (fall_ch_s) begin
          state_d = CALC;
        end else if (width_q == WIDTH_MAX) begin
          state_d   = DONE;
          timeout_s = 1'b1;
        end else begin
          width_d = width_q + CNT_W'(1);
        end
      end
      CALC: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (slot_cnt_q == PERIOD_LAST) begin
          ch_d = wrap_s ? '0 : ch_q + CH_W'(1);
          if (!bus.enable || (bus.single_shot && wrap_s)) begin
            state_d = IDLE;
          end else begin
            state_d = TRIG;
          end
        end else begin
          state_d = HOLDOFF;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // slot timer: zero on every trigger start so slots are exactly PERIOD_CYC long
  always_comb begin
    if ((state_d == TRIG) && (state_q != TRIG)) begin
      slot_cnt_d = '0;
    end else if (state_q != IDLE) begin
      slot_cnt_d = slot_cnt_q + CNT_W'(1);
    end else begin
      slot_cnt_d = slot_cnt_q;
    end
  end

  // trigger mask for the channel that will own the next cycle
  always_comb begin
    trig_s = '0;
    if (state_d == TRIG) begin
      trig_s[ch_d] = 1'b1;
    end else begin
      trig_s = '0;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      slot_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      width_q        <= '0;
      trigger_q      <= '0;
      dist_data_q    <= '0;
      dist_ch_q      <= '0;
      dist_valid_q   <= 1'b0;
      dist_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      slot_cnt_q   <= slot_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      width_q      <= width_d;
      trigger_q    <= trig_s;
      busy_q       <= (state_d != IDLE);
      dist_valid_q <= (state_d == DONE);
      if (state_d == DONE) begin
        dist_ch_q      <= ch_q;
        dist_timeout_q <= timeout_s;
        dist_data_q    <= timeout_s ? '1 : scaled_s;
      end
    end
  end

  assign bus.trigger_out  = trigger_q;
  assign bus.dist_data    = dist_data_q;
  assign bus.dist_ch      = dist_ch_q;
  assign bus.dist_valid   = dist_valid_q;
  assign bus.dist_timeout = dist_timeout_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_hcsr04_ranger_mc.sv
// Bench for hcsr04_ranger_mc: two instances (unit scale, and x3 into 4 bits)
// share stimulus; results are compared with a width/delay reference model.
module tb_hcsr04_ranger_mc;
  localparam int NUM_CH     = 2;
  localparam int TRIG_CYC   = 4;
  localparam int ECHO_TO    = 20;
  localparam int ECHO_MAX   = 40;
  localparam int PERIOD_CYC = 100;
  localparam int SYNC_LAT   = 2;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  hcsr04_ranger_mc_if #(.NUM_CH(NUM_CH), .DIST_W(8)) bus ();
  hcsr04_ranger_mc_if #(.NUM_CH(NUM_CH), .DIST_W(4)) bus2 ();

  assign bus2.enable      = bus.enable;
  assign bus2.single_shot = bus.single_shot;
  assign bus2.start       = bus.start;
  assign bus2.echo_in     = bus.echo_in;

  hcsr04_ranger_mc #(
    .NUM_CH(NUM_CH), .TRIG_CYC(TRIG_CYC), .ECHO_TO(ECHO_TO), .ECHO_MAX(ECHO_MAX),
    .PERIOD_CYC(PERIOD_CYC), .CNT_W(23), .SCALE_MUL(1), .SCALE_SHIFT(0), .DIST_W(8)
  ) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  hcsr04_ranger_mc #(
    .NUM_CH(NUM_CH), .TRIG_CYC(TRIG_CYC), .ECHO_TO(ECHO_TO), .ECHO_MAX(ECHO_MAX),
    .PERIOD_CYC(PERIOD_CYC), .CNT_W(23), .SCALE_MUL(3), .SCALE_SHIFT(0), .DIST_W(4)
  ) dut_sat (.clk(clk), .n_rst(n_rst), .bus(bus2));

  typedef struct {
    logic [7:0] data;
    logic       ch;
    logic       to;
    logic [3:0] data2;
    int         cyc;
  } ev_t;

  ev_t ev_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  ev_total = 0;
  int  onehot_viol = 0;
  int  pair_viol = 0;
  int  trig_cnt[NUM_CH];
  int  trig_rise_cyc[NUM_CH];
  logic [NUM_CH-1:0] trig_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // result capture and trigger bookkeeping, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.dist_valid === 1'b1) begin
      ev_q.push_back('{bus.dist_data, bus.dist_ch, bus.dist_timeout, bus2.dist_data, cyc});
      ev_total <= ev_total + 1;
    end
    if (bus.dist_valid !== bus2.dist_valid) pair_viol <= pair_viol + 1;
    if ($countones(bus.trigger_out) > 1) onehot_viol <= onehot_viol + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.trigger_out[i] && !trig_prev[i]) begin
        trig_cnt[i]      <= trig_cnt[i] + 1;
        trig_rise_cyc[i] <= cyc;
      end
    end
    trig_prev <= bus.trigger_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the echo is seen SYNC_LAT cycles after it is driven and must be
  // seen before the ECHO_TO wait window closes; widths above ECHO_MAX time out.
  function automatic void model(input int d, input int w, input bit stuck, input int mul,
                                input int dw, output bit to, output int val);
    int full;
    int p;
    full = (1 << dw) - 1;
    to   = stuck || (w == 0) || (d + SYNC_LAT > ECHO_TO - 1) || (w > ECHO_MAX);
    p    = w * mul;
    if (to) val = full;
    else val = (p > full) ? full : p;
  endfunction

  task automatic trig_window(input int c, input bit stuck);
    int n;
    n = 0;
    while (bus.trigger_out[c] !== 1'b1 && n < 400) begin step(); n++; end
    chk("trig_rise", 32'(bus.trigger_out[c]), 32'd1);
    if (stuck) bus.echo_in[c] = 1'b1;
    n = 0;
    while (bus.trigger_out[c] === 1'b1 && n < 50) begin step(); n++; end
    chk("trig_width", n, TRIG_CYC);
  endtask

  task automatic serve(input int c, input int d, input int w, input bit stuck,
                       input bit noise, input int drop);
    int  n;
    int  clr_cyc;
    bit  exp_to;
    int  exp_d;
    int  exp_d2;
    ev_t ev;
    clr_cyc = 0;
    trig_window(c, stuck);
    if (!stuck && w > 0) begin
      repeat (d) step();
      bus.echo_in[c] = 1'b1;
      if (noise) bus.echo_in[1-c] = 1'b1;
      for (int k = 0; k < w; k++) begin
        if (k == drop) bus.enable = 1'b0;
        step();
      end
      bus.echo_in = '0;
      clr_cyc = cyc;
    end
    n = 0;
    while (ev_q.size() == 0 && n < 300) begin step(); n++; end
    chk("valid_seen", 32'(ev_q.size() != 0), 32'd1);
    if (stuck) bus.echo_in = '0;
    if (ev_q.size() != 0) begin
      ev = ev_q.pop_front();
      model(d, w, stuck, 1, 8, exp_to, exp_d);
      model(d, w, stuck, 3, 4, exp_to, exp_d2);
      chk("dist_ch", 32'(ev.ch), c);
      chk("dist_timeout", 32'(ev.to), 32'(exp_to));
      chk("dist_data", 32'(ev.data), exp_d);
      chk("dist_data_sat", 32'(ev.data2), exp_d2);
      if (!exp_to) chk("fall_to_valid", ev.cyc - clr_cyc, 4);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin step(); n++; end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_trig"}, 32'(bus.trigger_out), 32'd0);
    chk({tag, "_data"}, 32'(bus.dist_data), 32'd0);
    chk({tag, "_ch"}, 32'(bus.dist_ch), 32'd0);
    chk({tag, "_valid"}, 32'(bus.dist_valid), 32'd0);
    chk({tag, "_to"}, 32'(bus.dist_timeout), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base;
    int t1;
    int t_all;
    n_rst           = 1'b0;
    bus.enable      = 1'b0;
    bus.single_shot = 1'b0;
    bus.start       = 1'b0;
    bus.echo_in     = '0;
    repeat (3) step();
    chk_outputs_zero("reset");
    n_rst = 1'b1;
    repeat (3) step();
    chk("idle_when_disabled", 32'(bus.busy), 32'd0);

    // continuous mode: directed slots, then random ones
    bus.enable = 1'b1;
    serve(0, 5, 10, 1'b0, 1'b0, -1);
    serve(1, 0, 0, 1'b0, 1'b0, -1);
    serve(0, 3, 60, 1'b0, 1'b0, -1);
    chk("slot_period", trig_rise_cyc[0] - trig_rise_cyc[1], PERIOD_CYC);
    serve(1, 0, 0, 1'b1, 1'b0, -1);
    serve(0, 0, 40, 1'b0, 1'b0, -1);
    serve(1, 2, 41, 1'b0, 1'b0, -1);
    serve(0, 17, 6, 1'b0, 1'b0, -1);
    serve(1, 18, 6, 1'b0, 1'b0, -1);
    for (int i = 0; i < 12; i++) begin
      serve(i % 2, int'($urandom_range(0, 19)), int'($urandom_range(1, 60)), 1'b0,
            1'($urandom_range(0, 1)), -1);
    end
    bus.enable = 1'b0;
    wait_idle("idle_after_disable");
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;

    // single-shot: one start gives one pass over both channels
    bus.single_shot = 1'b1;
    bus.enable      = 1'b1;
    repeat (5) step();
    chk("ss_waits_for_start", 32'(bus.busy), 32'd0);
    base      = ev_total;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    serve(0, 2, 7, 1'b0, 1'b0, -1);
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    serve(1, 4, 12, 1'b0, 1'b0, -1);
    wait_idle("ss_idle_after_pass");
    t_all = trig_cnt[0] + trig_cnt[1];
    repeat (150) step();
    chk("ss_strobe_count", ev_total - base, 2);
    chk("ss_no_extra_trig", trig_cnt[0] + trig_cnt[1], t_all);

    // enable dropped during ch0 measurement: result still delivered, ch1 never triggered
    t1 = trig_cnt[1];
    bus.single_shot = 1'b0;
    serve(0, 2, 8, 1'b0, 1'b0, 3);
    wait_idle("drop_idle");
    repeat (150) step();
    chk("drop_no_ch1_trig", trig_cnt[1], t1);

    // reset in the middle of a ch1 measurement
    bus.enable = 1'b1;
    trig_window(1, 1'b0);
    repeat (2) step();
    bus.echo_in[1] = 1'b1;
    repeat (4) step();
    n_rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    bus.echo_in = '0;
    bus.enable  = 1'b0;
    step();
    n_rst = 1'b1;
    repeat (3) step();

    chk("trigger_onehot", onehot_viol, 0);
    chk("instances_in_step", pair_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
